// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops a one-cycle-latency FIFO into a valid/ready stream
// A 3-entry skid buffer covers the in-flight read so the FIFO pop never depends on m_ready_i.
module fifo_stream_reader #(
  parameter int  DATA_WIDTH = 32,
  localparam int DW         = (DATA_WIDTH < 1) ? 1 : DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty_i,
  output logic          fifo_rd_en_o,
  input  logic [DW-1:0] fifo_rd_data_i,
  input  logic          flush_i,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  input  logic          m_ready_i,
  output logic [1:0]    level_o
);

  logic [DW-1:0] mem_q [3];
  logic [1:0]    head_q, tail_q, occ_q;
  logic          pend_q, valid_q;
  logic [DW-1:0] data_q;

  logic          capture, pop;
  logic [1:0]    head_n, tail_n, occ_n, occ_left;
  logic [DW-1:0] data_n;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for the word already in flight, so the buffer can never overflow.
  assign fifo_rd_en_o = ~rst & ~flush_i & ~fifo_empty_i &
                        (({1'b0, occ_q} + {2'b00, pend_q}) < 3'd3);

  always_comb begin
    capture  = pend_q & ~flush_i;
    pop      = valid_q & m_ready_i;
    head_n   = pop ? wrap_inc(head_q) : head_q;
    tail_n   = capture ? wrap_inc(tail_q) : tail_q;
    occ_left = occ_q - {1'b0, pop};
    occ_n    = occ_left + {1'b0, capture};
    // The new head is the word being captured when nothing else remains buffered.
    if (capture && (occ_left == 2'd0)) begin
      data_n = fifo_rd_data_i;
    end else begin
      data_n = mem_q[head_n];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[tail_q] <= fifo_rd_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      occ_q   <= 2'd0;
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      pend_q <= fifo_rd_en_o;
      if (flush_i) begin
        occ_q   <= 2'd0;
        head_q  <= 2'd0;
        tail_q  <= 2'd0;
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        occ_q   <= occ_n;
        head_q  <= head_n;
        tail_q  <= tail_n;
        valid_q <= (occ_n != 2'd0);
        data_q  <= data_n;
      end
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign level_o   = occ_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic [1:0]  level;

  int errors = 0;
  int checks = 0;

  fifo_stream_reader #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .flush_i        (flush),
    .m_valid_o      (m_valid),
    .m_data_o       (m_data),
    .m_ready_i      (m_ready),
    .level_o        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency
  logic [31:0] fmem [64];
  int unsigned wr_cnt = 0;
  int unsigned rd_idx = 0;
  logic        fifo_clr = 1'b0;
  initial fifo_rd_data = 32'h0;
  assign fifo_empty = (rd_idx == wr_cnt);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_idx <= wr_cnt;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_idx[5:0]];
      rd_idx       <= rd_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fmem[wr_cnt[5:0]] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  // Stream monitor: collects accepted words and checks hold/overflow rules
  logic [31:0] rx [$];
  logic        prev_valid = 1'b0;
  logic        prev_pop   = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_data  = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (prev_valid && !prev_pop && !prev_flush) begin
        check("hold_valid", {31'b0, m_valid}, 32'd1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready && !flush) rx.push_back(m_data);
      if (level == 2'd3) check("no_overflow", {31'b0, dut.pend_q}, 32'd0);
      prev_valid <= m_valid;
      prev_pop   <= m_valid & m_ready;
      prev_flush <= flush;
      prev_data  <= m_data;
    end
  end

  logic [7:0] t4_ready;
  int         pulses;

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b1;
    push(32'h11); push(32'h12); push(32'h13); push(32'h14);

    // reset held with the FIFO non-empty
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      check("rst_valid", {31'b0, m_valid}, 32'd0);
      check("rst_level", {30'b0, level}, 32'd0);
    end

    // release, then 4-word burst at full rate
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("t2_rd_en", {31'b0, fifo_rd_en}, {31'b0, (c <= 3)});
      check("t2_valid", {31'b0, m_valid}, {31'b0, (c >= 2 && c <= 5)});
      if (c >= 2 && c <= 5) check("t2_data", m_data, 32'h11 + c - 2);
    end

    // consumer stalled: exactly three reads fill the buffer
    m_ready = 1'b0;
    rx.delete();
    for (int k = 0; k < 6; k++) push(32'h21 + k);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (fifo_rd_en) pulses = pulses + 1;
      @(negedge clk);
    end
    #1;
    check("t3_pulses", pulses, 32'd3);
    check("t3_level", {30'b0, level}, 32'd3);
    check("t3_rd_en_full", {31'b0, fifo_rd_en}, 32'd0);
    m_ready = 1'b1;
    #1;
    check("t3_rd_en_raise", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk); #1;
    check("t3_rd_en_resume", {31'b0, fifo_rd_en}, 32'd1);
    check("t3_level_resume", {30'b0, level}, 32'd2);
    for (int i = 0; i < 30 && rx.size() < 6; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t3_count", rx.size(), 32'd6);
    for (int k = 0; k < 6; k++)
      check("t3_order", (k < rx.size()) ? rx[k] : 32'hDEADDEAD, 32'h21 + k);

    // FIFO runs dry after two words, ready toggles while valid
    #1;
    rx.delete();
    t4_ready = 8'b1111_0111;
    push(32'h31); push(32'h32);
    for (int c = 0; c < 8; c++) begin
      m_ready = t4_ready[c];
      #1;
      if (fifo_empty) check("t4_no_read_empty", {31'b0, fifo_rd_en}, 32'd0);
      @(negedge clk);
    end
    #1;
    check("t4_count", rx.size(), 32'd2);
    check("t4_w0", (rx.size() > 0) ? rx[0] : 32'hDEADDEAD, 32'h31);
    check("t4_w1", (rx.size() > 1) ? rx[1] : 32'hDEADDEAD, 32'h32);
    check("t4_valid_low", {31'b0, m_valid}, 32'd0);

    // flush with two words buffered and one returning
    m_ready = 1'b0;
    rx.delete();
    push(32'h41); push(32'h42); push(32'h43);
    repeat (3) @(negedge clk);
    #1;
    check("t5_pre_level", {30'b0, level}, 32'd2);
    check("t5_pre_pend", {31'b0, dut.pend_q}, 32'd1);
    flush = 1'b1;
    #1;
    check("t5_no_read_flush", {31'b0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("t5_valid", {31'b0, m_valid}, 32'd0);
    check("t5_level", {30'b0, level}, 32'd0);
    push(32'hAA);
    m_ready = 1'b1;
    for (int i = 0; i < 10 && rx.size() < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t5_count", rx.size(), 32'd1);
    check("t5_first", (rx.size() > 0) ? rx[0] : 32'hDEADDEAD, 32'hAA);

    // asynchronous reset mid-burst
    for (int k = 0; k < 5; k++) push(32'h51 + k);
    repeat (3) @(negedge clk);
    #2;
    check("t6_pre_valid", {31'b0, m_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_valid", {31'b0, m_valid}, 32'd0);
    check("t6_level", {30'b0, level}, 32'd0);
    check("t6_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    fifo_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fifo_clr = 1'b0;
    rx.delete();
    repeat (6) @(negedge clk);
    #1;
    check("t6_no_word", rx.size(), 32'd0);
    check("t6_valid_after", {31'b0, m_valid}, 32'd0);
    check("t6_level_after", {30'b0, level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
